// File: rtl/blk_raster_reorder.sv
// Frame reorder engine: buffers one full frame, then streams it back out in
// raster order (mode 0, block input) or block order (mode 1, raster input).
// The permutation happens on the write side; the drain always reads 0..N-1.
module blk_raster_reorder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned BLK    = 8,
  parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned NPix = IMG_W * IMG_H;
  localparam int unsigned NBx  = IMG_W / BLK;
  localparam int unsigned NBy  = IMG_H / BLK;
  localparam int unsigned CW   = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int unsigned BxW  = (NBx > 1) ? $clog2(NBx) : 1;
  localparam int unsigned ByW  = (NBy > 1) ? $clog2(NBy) : 1;

  localparam logic [CW-1:0]     CMax     = CW'(BLK - 1);
  localparam logic [BxW-1:0]    BxMax    = BxW'(NBx - 1);
  localparam logic [ByW-1:0]    ByMax    = ByW'(NBy - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NPix - 1);

  // Geometry sanity check at elaboration time.
  if (((IMG_W % BLK) != 0) || ((IMG_H % BLK) != 0) || (BLK < 2) || (BLK > 32) ||
      ((BLK & (BLK - 1)) != 0)) begin : g_param_err
    $error("blk_raster_reorder: IMG_W/IMG_H must be multiples of BLK, BLK a power of two 2..32");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [CW-1:0]       c_q, c_d;
  logic [CW-1:0]       r_q, r_d;
  logic [BxW-1:0]      bx_q, bx_d;
  logic [ByW-1:0]      by_q, by_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_done_q, rd_done_d;
  logic                ra_valid_q, ra_valid_d;
  logic                ra_last_q, ra_last_d;
  logic [DATA_W-1:0]   ra_data_q;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem_q [NPix];

  logic                s_hs, m_hs, ra_move, rd_en;
  logic                c_wrap, r_wrap, bx_wrap, by_wrap, in_last;
  logic [ADDR_W-1:0]   wr_addr;

  assign s_ready_o = (state_q == StLoad);
  assign busy_o    = (state_q != StIdle);
  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;
  assign done_o    = done_q;

  // Handshakes and pipeline moves are all qualified by en_i so a low enable freezes everything.
  assign s_hs    = en_i & s_valid_i & s_ready_o;
  assign m_hs    = en_i & m_valid_q & m_ready_i;
  assign ra_move = en_i & ra_valid_q & (~m_valid_q | m_ready_i);
  // Only read when the RAM output register is empty or being emptied this cycle.
  assign rd_en   = en_i & (state_q == StDrain) & ~rd_done_q & (~ra_valid_q | ra_move);

  assign c_wrap  = (c_q == CMax);
  assign r_wrap  = (r_q == CMax);
  assign bx_wrap = (bx_q == BxMax);
  assign by_wrap = (by_q == ByMax);
  assign in_last = c_wrap & r_wrap & bx_wrap & by_wrap;

  // Mode 0 scatters block-ordered input to raster addresses; mode 1 scatters raster input
  // to block-ordered addresses.
  assign wr_addr = mode_q ?
      ADDR_W'(((32'(by_q) * NBx + 32'(bx_q)) * BLK + 32'(r_q)) * BLK + 32'(c_q)) :
      ADDR_W'((32'(by_q) * BLK + 32'(r_q)) * IMG_W + 32'(bx_q) * BLK + 32'(c_q));

  // Next-state: FSM, write counters and the two-stage read pipeline.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    c_d        = c_q;
    r_d        = r_q;
    bx_d       = bx_q;
    by_d       = by_q;
    rd_addr_d  = rd_addr_q;
    rd_done_d  = rd_done_q;
    ra_valid_d = ra_valid_q;
    ra_last_d  = ra_last_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    done_d     = done_q;

    if (en_i) begin
      done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d    = StLoad;
            mode_d     = mode_i;
            c_d        = '0;
            r_d        = '0;
            bx_d       = '0;
            by_d       = '0;
            rd_addr_d  = '0;
            rd_done_d  = 1'b0;
            ra_valid_d = 1'b0;
            ra_last_d  = 1'b0;
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
          end
        end

        StLoad: begin
          if (s_hs) begin
            c_d = c_wrap ? '0 : c_q + CW'(1);
            if (!mode_q) begin
              // c, then r, then bx, then by
              if (c_wrap) r_d = r_wrap ? '0 : r_q + CW'(1);
              if (c_wrap && r_wrap) bx_d = bx_wrap ? '0 : bx_q + BxW'(1);
              if (c_wrap && r_wrap && bx_wrap) by_d = by_wrap ? '0 : by_q + ByW'(1);
            end else begin
              // c, then bx, then r, then by
              if (c_wrap) bx_d = bx_wrap ? '0 : bx_q + BxW'(1);
              if (c_wrap && bx_wrap) r_d = r_wrap ? '0 : r_q + CW'(1);
              if (c_wrap && bx_wrap && r_wrap) by_d = by_wrap ? '0 : by_q + ByW'(1);
            end
            if (in_last) state_d = StDrain;
          end
        end

        StDrain: begin
          if (rd_en) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            if (rd_addr_q == LastAddr) rd_done_d = 1'b1;
          end

          if (rd_en) begin
            ra_valid_d = 1'b1;
            ra_last_d  = (rd_addr_q == LastAddr);
          end else if (ra_move) begin
            ra_valid_d = 1'b0;
          end

          if (ra_move) begin
            m_valid_d = 1'b1;
            m_data_d  = ra_data_q;
            m_last_d  = ra_last_q;
          end else if (m_hs) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end

          if (m_hs && m_last_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  // State and control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      c_q        <= '0;
      r_q        <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      rd_addr_q  <= '0;
      rd_done_q  <= 1'b0;
      ra_valid_q <= 1'b0;
      ra_last_q  <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      c_q        <= c_d;
      r_q        <= r_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      rd_addr_q  <= rd_addr_d;
      rd_done_q  <= rd_done_d;
      ra_valid_q <= ra_valid_d;
      ra_last_q  <= ra_last_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      done_q     <= done_d;
    end
  end

  // Frame buffer: one write port, one registered read port (no reset, RAM-inferable).
  always_ff @(posedge clk_i) begin
    if (s_hs) mem_q[wr_addr] <= s_data_i;
    if (rd_en) ra_data_q <= mem_q[rd_addr_q];
  end

endmodule

// File: tb/tb_blk_raster_reorder.sv
// Directed bench for blk_raster_reorder with a 16x8 frame and 4x4 blocks.
module tb_blk_raster_reorder;

  localparam int unsigned N = 128;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       en_i = 1'b0;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic [7:0] s_data_i = '0;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic       m_last_o;
  logic       busy_o;
  logic       done_o;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] in_px   [N];
  logic [7:0] out_px  [N];
  logic [7:0] base_px [N];
  logic [7:0] m1_px   [N];

  blk_raster_reorder #(
    .DATA_W(8),
    .IMG_W (16),
    .IMG_H (8),
    .BLK   (4)
  ) u_dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (en_i),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .s_data_i (s_data_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_last_o (m_last_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Block-ordered index of the pixel found at raster position i.
  function automatic int b2r_exp(input int i);
    int y, x;
    y = i / 16;
    x = i % 16;
    return (((y / 4) * 4 + x / 4) * 4 + y % 4) * 4 + x % 4;
  endfunction

  // Raster index of the pixel found at block-ordered position i.
  function automatic int r2b_exp(input int i);
    int c, r, bx, by;
    c  = i % 4;
    r  = (i / 4) % 4;
    bx = (i / 16) % 4;
    by = i / 64;
    return (by * 4 + r) * 16 + bx * 4 + c;
  endfunction

  function automatic int seq_diff_base();
    int d = 0;
    for (int i = 0; i < N; i++) if (out_px[i] != base_px[i]) d++;
    return d;
  endfunction

  // One full frame; cyc counts cycles from start acceptance to the last output handshake.
  task automatic run_frame(input bit mode, input bit rnd, input int stall_at, input int en_in_at,
                           input int en_out_at, input bit start_in_drain, output int cyc,
                           output int first_vld, output int n_in, output int errs_last,
                           output int errs_flow, output int errs_hold);
    int n_out = 0;
    int gap_left = 0;
    int stall_left = 0;
    bit gin = 0, gout = 0, stl = 0, sdn = 0, fin = 0;
    logic [7:0] stall_val = '0;
    cyc = 0; first_vld = 0; n_in = 0; errs_last = 0; errs_flow = 0; errs_hold = 0;
    for (int i = 0; i < N; i++) out_px[i] = '0;

    @(negedge clk_i);
    en_i = 1'b1; start_i = 1'b1; mode_i = mode; s_valid_i = 1'b0; m_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; mode_i = !mode;

    while (!fin) begin
      cyc++;
      if (cyc > 3000) begin
        check_eq("frame_timeout", cyc, 0);
        break;
      end
      if (en_in_at >= 0 && !gin && n_in == en_in_at) begin gin = 1; gap_left = 5; end
      if (en_out_at >= 0 && !gout && n_out == en_out_at) begin gout = 1; gap_left = 5; end
      en_i = (gap_left == 0);
      if (gap_left > 0) gap_left--;

      s_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = (n_in < N) ? in_px[n_in] : 8'hEE;
      start_i   = 1'b0;
      mode_i    = !mode;
      if (start_in_drain && !sdn && n_out == 10) begin sdn = 1; start_i = 1'b1; mode_i = 1'b1; end

      if (stall_at >= 0 && !stl && n_out == stall_at && m_valid_o) begin
        stl = 1; stall_left = 3; stall_val = m_data_o;
      end
      m_ready_i = 1'b1;
      if (stall_left > 0) begin
        m_ready_i = 1'b0;
        stall_left--;
        if (!(m_valid_o && m_data_o == stall_val)) errs_hold++;
      end

      if (!busy_o || done_o) errs_flow++;
      if (m_valid_o && first_vld == 0) first_vld = cyc;
      if (en_i && s_valid_i && s_ready_o) n_in++;
      if (en_i && m_valid_o && m_ready_i) begin
        if (n_out < N) out_px[n_out] = m_data_o;
        if (m_last_o != (n_out == N - 1)) errs_last++;
        if (m_last_o) fin = 1;
        n_out++;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    s_valid_i = 1'b0;
    if (!(done_o && !busy_o)) errs_flow++;
    @(negedge clk_i);
    if (done_o) errs_flow++;
  endtask

  int cyc, fv, nin, el, ef, eh, d, k;

  initial begin
    for (int i = 0; i < N; i++) in_px[i] = 8'(i);

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("reset_outputs", int'({s_ready_o, m_valid_o, m_last_o, busy_o, done_o, m_data_o}), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Mode 0, continuous
    run_frame(0, 0, -1, -1, -1, 0, cyc, fv, nin, el, ef, eh);
    check_eq("m0_cycles", cyc, 258);
    check_eq("m0_first_valid", fv, 131);
    check_eq("m0_out0", int'(out_px[0]), 0);
    check_eq("m0_out4", int'(out_px[4]), 16);
    check_eq("m0_out16", int'(out_px[16]), 4);
    check_eq("m0_out127", int'(out_px[127]), 127);
    d = 0;
    for (int i = 0; i < N; i++) if (int'(out_px[i]) != b2r_exp(i)) d++;
    check_eq("m0_model_diffs", d, 0);
    check_eq("m0_last_errs", el, 0);
    check_eq("m0_flow_errs", ef, 0);
    check_eq("m0_inputs_taken", nin, 128);
    for (int i = 0; i < N; i++) base_px[i] = out_px[i];

    // Mode 1, same stimulus
    run_frame(1, 0, -1, -1, -1, 0, cyc, fv, nin, el, ef, eh);
    check_eq("m1_out4", int'(out_px[4]), 16);
    check_eq("m1_out16", int'(out_px[16]), 4);
    check_eq("m1_out20", int'(out_px[20]), 20);
    d = 0;
    for (int i = 0; i < N; i++) if (int'(out_px[i]) != r2b_exp(i)) d++;
    check_eq("m1_model_diffs", d, 0);
    check_eq("m1_last_errs", el, 0);
    check_eq("m1_flow_errs", ef, 0);
    for (int i = 0; i < N; i++) m1_px[i] = out_px[i];

    // Mode 1 output back through mode 0 restores raster order
    for (int i = 0; i < N; i++) in_px[i] = m1_px[i];
    run_frame(0, 0, -1, -1, -1, 0, cyc, fv, nin, el, ef, eh);
    d = 0;
    for (int i = 0; i < N; i++) if (int'(out_px[i]) != i) d++;
    check_eq("roundtrip_diffs", d, 0);
    for (int i = 0; i < N; i++) in_px[i] = 8'(i);

    // Backpressure at output 50 plus random input valid
    run_frame(0, 1, 50, -1, -1, 0, cyc, fv, nin, el, ef, eh);
    check_eq("stall_hold_errs", eh, 0);
    check_eq("stall_seq_diffs", seq_diff_base(), 0);
    check_eq("stall_last_errs", el, 0);
    check_eq("stall_inputs_taken", nin, 128);

    // Enable gaps of 5 cycles in LOAD and in DRAIN
    run_frame(0, 0, -1, 40, 60, 0, cyc, fv, nin, el, ef, eh);
    check_eq("engap_seq_diffs", seq_diff_base(), 0);
    check_eq("engap_cycles", cyc, 268);
    check_eq("engap_flow_errs", ef, 0);

    // Reset asserted after 60 input pixels
    @(negedge clk_i);
    en_i = 1'b1; start_i = 1'b1; mode_i = 1'b0; m_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    k = 0;
    for (int t = 0; t < 500 && k < 60; t++) begin
      s_valid_i = 1'b1;
      s_data_i  = in_px[k];
      if (s_ready_o) k++;
      @(negedge clk_i);
    end
    check_eq("rst_inputs_before", k, 60);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rst_async_outputs",
             int'({s_ready_o, m_valid_o, m_last_o, busy_o, done_o, m_data_o}), 0);
    s_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_frame(0, 0, -1, -1, -1, 0, cyc, fv, nin, el, ef, eh);
    check_eq("post_rst_seq_diffs", seq_diff_base(), 0);
    check_eq("post_rst_cycles", cyc, 258);

    // start_i with mode_i=1 during DRAIN is ignored
    run_frame(0, 0, -1, -1, -1, 1, cyc, fv, nin, el, ef, eh);
    check_eq("drain_start_seq_diffs", seq_diff_base(), 0);
    check_eq("drain_start_flow_errs", ef, 0);
    check_eq("drain_start_cycles", cyc, 258);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/blk_raster_reorder.md
Name: blk_raster_reorder

Overview:
- Parametrised frame reorder engine; successor to the fixed 8x8 / 320x240 block-to-raster converter.
- Buffers one full frame of pixels, then streams it out in a permuted order.
- Runtime mode selects block-to-raster (codec output toward display/file path) or raster-to-block (camera input toward block codec).
- Valid/ready streaming on both sides replaces fixed-gap pacing. Sits between the image source/sink and the block-processing cores.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 320, image width in pixels; must be a multiple of BLK.
- IMG_H, 240, image height in pixels; must be a multiple of BLK.
- BLK, 8, block edge in pixels; power of two, 2..32.
- ADDR_W, $clog2(IMG_W*IMG_H), frame buffer address width (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  global enable; when low all state, counters and outputs freeze.
- start_i  in  1  frame start pulse, honoured only in IDLE.
- mode_i  in  1  0 = block-to-raster, 1 = raster-to-block; sampled on the accepted start.
- s_data_i  in  DATA_W  input pixel.
- s_valid_i  in  1  input pixel valid.
- s_ready_o  out  1  engine accepts input pixel.
- m_data_o  out  DATA_W  output pixel.
- m_valid_o  out  1  output pixel valid.
- m_ready_i  in  1  sink accepts output pixel.
- m_last_o  out  1  high with the final pixel of the frame.
- busy_o  out  1  high from accepted start until the last output handshake.
- done_o  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, mode register 0; s_ready_o, m_valid_o, m_last_o, busy_o, done_o = 0; m_data_o = 0.
- Elaboration check: $error if IMG_W%BLK, IMG_H%BLK or BLK is not a power of two.
- Frame buffer: single-port-per-side RAM, IMG_W*IMG_H x DATA_W, one write port, one read port with 1-cycle registered read.
- States and transitions:
  - IDLE: on start_i & en_i, latch mode_i, clear counters, assert busy_o, go to LOAD.
  - LOAD:
    - s_ready_o = 1.
    - Each s_valid_i & s_ready_o handshake writes s_data_i to the write address, then advances the counters.
    - On the IMG_W*IMG_H-th handshake, s_ready_o drops the next cycle and the state goes to DRAIN.
  - DRAIN:
    - Reads addresses 0..N-1 sequentially.
    - Output register plus one read-ahead stage. No bubbles while m_ready_i is high; the first m_valid_o rises 2 cycles after DRAIN entry.
    - When m_ready_i is low, m_data_o, m_valid_o and m_last_o hold stable. No drop, no duplicate.
    - m_last_o asserts with pixel N-1. After its handshake: done_o pulses, busy_o drops, state goes to IDLE.
- Write address generation uses counters c (col in block), r (row in block), bx (block col), by (block row). The nesting order depends on the mode:
  - mode 0 (input in block order): c fastest, then r, bx, by. addr = (by*BLK+r)*IMG_W + bx*BLK + c.
  - mode 1 (input in raster order): c fastest, then bx, r, by. addr = ((by*(IMG_W/BLK)+bx)*BLK + r)*BLK + c.
  - Each counter wraps at its limit (BLK, BLK, IMG_W/BLK, IMG_H/BLK) and carries into the next. No multipliers required if implemented with incremental base registers; either form is acceptable if timing is met.
- Boundaries:
  - start_i outside IDLE is ignored.
  - mode_i changes outside an accepted start have no effect.
  - en_i low in any state freezes everything, including a pending m_valid_o, which is held. The handshake is not evaluated while en_i is low.
  - rst_ni asserted mid-LOAD or mid-DRAIN aborts the frame. Buffer contents are don't-care; the next frame is fully correct.
  - s_valid_i in IDLE or DRAIN is not accepted (s_ready_o = 0).

Test Plan:
- Use IMG_W=16, IMG_H=8, BLK=4 (N=128); input pixel n = n mod 256.
- Mode 0, continuous valid/ready -> output 0 = 0, output 4 = 16, output 16 = 4, output 127 = 127. m_last_o only on output 127; done_o pulses once; busy_o = 0 afterwards.
- Mode 1, same stimulus -> output 4 = 16, output 16 = 4, output 20 = 20 (block 1 row 1 = raster (1,4)). Feeding the mode-1 output back through mode 0 reproduces 0..127 in order.
- Backpressure: m_ready_i low for 3 cycles at output 50, and random 50% s_valid_i during LOAD -> m_data_o holds 50's value while stalled; full sequence identical to the unstalled run.
- en_i low for 5 cycles mid-LOAD and mid-DRAIN -> no handshakes occur; frame result is identical; cycle count grows by exactly 10.
- rst_ni low at input pixel 60 -> all outputs 0 asynchronously; a following start plus a full frame in mode 0 matches the first test exactly.
- start_i pulsed during DRAIN with mode_i=1 -> ignored; frame completes in mode 0; busy_o stays high continuously until done_o.
